// File: rtl/cu_pkg.sv
// Shared types and constants for the ProjectB control unit: state encodings,
// opcodes, ALU selects and field widths.
package cu_pkg;

  localparam int IRW  = 16;
  localparam int OPW  = 4;
  localparam int AW   = 8;
  localparam int RW   = 4;
  localparam int ALUW = 3;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [OPW-1:0] OP_NOOP  = 4'd0;
  localparam logic [OPW-1:0] OP_STORE = 4'd1;
  localparam logic [OPW-1:0] OP_LOAD  = 4'd2;
  localparam logic [OPW-1:0] OP_ADD   = 4'd3;
  localparam logic [OPW-1:0] OP_SUB   = 4'd4;
  localparam logic [OPW-1:0] OP_HALT  = 4'd5;

  localparam logic [ALUW-1:0] ALU_PASS = 3'd0;
  localparam logic [ALUW-1:0] ALU_ADD  = 3'd1;
  localparam logic [ALUW-1:0] ALU_SUB  = 3'd2;

  function automatic logic op_legal(input logic [OPW-1:0] op);
    return op <= OP_HALT;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction input and datapath control outputs of the control unit.
// master = control unit, slave = datapath side.
interface control_unit_if;
  import cu_pkg::*;

  logic [IRW-1:0]  ir;
  logic            pc_clr;
  logic            pc_up;
  logic            ir_ld;
  logic [AW-1:0]   d_addr;
  logic            d_wr;
  logic            rf_s;
  logic [RW-1:0]   rf_w_addr;
  logic            rf_w_wr;
  logic [RW-1:0]   rf_ra_addr;
  logic            rf_ra_rd;
  logic [RW-1:0]   rf_rb_addr;
  logic            rf_rb_rd;
  logic [ALUW-1:0] alu_s0;
  logic            halted;
  logic            illegal;
  logic [3:0]      state;

  modport master (
    input  ir,
    output pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, rf_w_addr, rf_w_wr,
           rf_ra_addr, rf_ra_rd, rf_rb_addr, rf_rb_rd, alu_s0, halted,
           illegal, state
  );

  modport slave (
    output ir,
    input  pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, rf_w_addr, rf_w_wr,
           rf_ra_addr, rf_ra_rd, rf_rb_addr, rf_rb_rd, alu_s0, halted,
           illegal, state
  );

endinterface

// File: rtl/cu_instr_decode.sv
// Combinational instruction field extraction for the control unit.
module cu_instr_decode
  import cu_pkg::*;
(
  input  logic [IRW-1:0] ir,
  output logic [OPW-1:0] opcode,
  output logic [AW-1:0]  addr,
  output logic [RW-1:0]  mreg,
  output logic [RW-1:0]  ra,
  output logic [RW-1:0]  rb,
  output logic [RW-1:0]  rd,
  output logic           legal
);

  // LOAD/STORE and ADD/SUB views overlap the same IR bits.
  assign opcode = ir[15:12];
  assign addr   = ir[11:4];
  assign mreg   = ir[3:0];
  assign ra     = ir[11:8];
  assign rb     = ir[7:4];
  assign rd     = ir[3:0];
  assign legal  = op_legal(ir[15:12]);

endmodule

// File: rtl/control_unit.sv
// ProjectB main control FSM: fetch/decode/execute sequencing with Moore outputs.
// Optional macro CU_ILLEGAL_TRAP_EN: undefined opcodes halt and set sticky illegal.
module control_unit
  import cu_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  control_unit_if.master bus
);

  state_t          state_q, state_d;
  logic [OPW-1:0]  opcode;
  logic [AW-1:0]   addr;
  logic [RW-1:0]   mreg, ra, rb, rd;
  logic            legal;

`ifdef CU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  cu_instr_decode u_dec (
    .ir     (bus.ir),
    .opcode (opcode),
    .addr   (addr),
    .mreg   (mreg),
    .ra     (ra),
    .rb     (rb),
    .rd     (rd),
    .legal  (legal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_INIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (!legal) state_d = TRAP ? S_HALT : S_NOOP;
        else begin
          case (opcode)
            OP_STORE: state_d = S_STORE;
            OP_LOAD:  state_d = S_LOAD_A;
            OP_ADD:   state_d = S_ADD;
            OP_SUB:   state_d = S_SUB;
            OP_HALT:  state_d = S_HALT;
            default:  state_d = S_NOOP;
          endcase
        end
      end
      S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_d = S_FETCH;
      S_LOAD_A: state_d = S_LOAD_B;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  always_comb begin
    bus.pc_clr     = 1'b0;
    bus.pc_up      = 1'b0;
    bus.ir_ld      = 1'b0;
    bus.d_addr     = '0;
    bus.d_wr       = 1'b0;
    bus.rf_s       = 1'b0;
    bus.rf_w_addr  = '0;
    bus.rf_w_wr    = 1'b0;
    bus.rf_ra_addr = '0;
    bus.rf_ra_rd   = 1'b0;
    bus.rf_rb_addr = '0;
    bus.rf_rb_rd   = 1'b0;
    bus.alu_s0     = ALU_PASS;
    bus.halted     = 1'b0;
    bus.state      = state_q;
    case (state_q)
      S_INIT:   bus.pc_clr = 1'b1;
      S_FETCH: begin
        bus.ir_ld = 1'b1;
        bus.pc_up = 1'b1;
      end
      S_LOAD_A: bus.d_addr = addr;
      S_LOAD_B: begin
        bus.d_addr    = addr;
        bus.rf_s      = 1'b1;
        bus.rf_w_addr = mreg;
        bus.rf_w_wr   = 1'b1;
      end
      S_STORE: begin
        bus.d_addr     = addr;
        bus.rf_ra_addr = mreg;
        bus.rf_ra_rd   = 1'b1;
        bus.d_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        bus.rf_ra_addr = ra;
        bus.rf_ra_rd   = 1'b1;
        bus.rf_rb_addr = rb;
        bus.rf_rb_rd   = 1'b1;
        bus.alu_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
        bus.rf_w_addr  = rd;
        bus.rf_w_wr    = 1'b1;
      end
      S_HALT:   bus.halted = 1'b1;
      default:  ;
    endcase
  end

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           illegal_q <= 1'b0;
    else if (state_q == S_DECODE && !legal) illegal_q <= 1'b1;
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

endmodule
